// File: rtl/cbu_cascade_up_counter.sv
// Cascadable synchronous up-counter with preset, parallel load and combinational carry-out.
// Define CBU_MOD_LIMIT_EN to count modulo MODULUS instead of 2^WIDTH.
module cbu_cascade_up_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             CLK,
  input  logic             CDN,
  input  logic [WIDTH-1:0] D,
  input  logic             CAI,
  input  logic             PS,
  input  logic             LD,
  input  logic             EN,
  output logic [WIDTH-1:0] Q,
  output logic             CAO
);

  if ((WIDTH < 1) || (WIDTH > 16)) begin : g_bad_width
    $error("cbu_cascade_up_counter: WIDTH %0d outside 1..16", WIDTH);
  end
  if ((MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : g_bad_modulus
    $error("cbu_cascade_up_counter: MODULUS %0d outside 2..2^WIDTH", MODULUS);
  end

`ifdef CBU_MOD_LIMIT_EN
  localparam logic [WIDTH-1:0] TV = WIDTH'(MODULUS - 1);
`else
  localparam logic [WIDTH-1:0] TV = {WIDTH{1'b1}};
`endif
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1'b1);
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next_s;
  logic             at_s;

  // Terminal detection; the modulo build uses >= so loaded out-of-range values wrap on the next count.
`ifdef CBU_MOD_LIMIT_EN
  assign at_s = (q_r >= TV);
`else
  assign at_s = (q_r == TV);
`endif

  // Next-state selection: preset, then load, then count, then hold.
  always_comb begin
    q_next_s = q_r;
    if (PS) begin
      q_next_s = TV;
    end else if (LD) begin
      q_next_s = D;
    end else if (CAI && EN) begin
      if (at_s) begin
        q_next_s = ZERO;
      end else begin
        q_next_s = q_r + ONE;
      end
    end else begin
      q_next_s = q_r;
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      q_r <= ZERO;
    end else begin
      q_r <= q_next_s;
    end
  end

  assign Q = q_r;

  // Carry must be combinational so a cascade of stages rolls over on a single edge.
  assign CAO = CAI & EN & at_s;

endmodule

// File: tb/tb_cbu_cascade_up_counter.sv
// Scoreboard bench for cbu_cascade_up_counter: directed steps push expected Q, compared after each edge.
module tb_cbu_cascade_up_counter;

`ifdef CBU_MOD_LIMIT_EN
  localparam logic [3:0] TV_M = 4'd9;
`else
  localparam logic [3:0] TV_M = 4'd15;
`endif

  logic       CLK = 1'b0;
  logic       CDN = 1'b0;
  logic [3:0] D   = 4'd0;
  logic       CAI = 1'b0;
  logic       PS  = 1'b0;
  logic       LD  = 1'b0;
  logic       EN  = 1'b0;
  logic [3:0] Q;
  logic       CAO;

  // cascade pair
  logic       c0_ld = 1'b0, c1_ld = 1'b0, c_en = 1'b0;
  logic [3:0] c0_d = 4'd0, c1_d = 4'd0;
  logic [3:0] c0_q, c1_q;
  logic       c0_cao, c1_cao;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] m_q = 4'd0;
  logic [3:0] exp_q[$];

  always #5 CLK = ~CLK;

  cbu_cascade_up_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .CLK(CLK), .CDN(CDN), .D(D), .CAI(CAI), .PS(PS), .LD(LD), .EN(EN), .Q(Q), .CAO(CAO)
  );

  cbu_cascade_up_counter #(.WIDTH(4), .MODULUS(10)) stage0 (
    .CLK(CLK), .CDN(CDN), .D(c0_d), .CAI(1'b1), .PS(1'b0), .LD(c0_ld), .EN(c_en),
    .Q(c0_q), .CAO(c0_cao)
  );

  cbu_cascade_up_counter #(.WIDTH(4), .MODULUS(10)) stage1 (
    .CLK(CLK), .CDN(CDN), .D(c1_d), .CAI(c0_cao), .PS(1'b0), .LD(c1_ld), .EN(c_en),
    .Q(c1_q), .CAO(c1_cao)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic m_at(input logic [3:0] q);
`ifdef CBU_MOD_LIMIT_EN
    return (q >= TV_M);
`else
    return (q == TV_M);
`endif
  endfunction

  // Drive one step, check carry on the current state, then check Q after the edge.
  task automatic apply(input logic ps, input logic ld, input logic en, input logic cai,
                       input logic [3:0] d, input string tag);
    logic [3:0] nxt;
    logic [3:0] e;
    PS = ps; LD = ld; EN = en; CAI = cai; D = d;
    #1;
    chk({tag, "_cao"}, {3'd0, CAO}, {3'd0, cai & en & m_at(m_q)});
    if (ps)              nxt = TV_M;
    else if (ld)         nxt = d;
    else if (cai && en)  nxt = m_at(m_q) ? 4'd0 : m_q + 4'd1;
    else                 nxt = m_q;
    exp_q.push_back(nxt);
    m_q = nxt;
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    chk({tag, "_q"}, Q, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state before any clock edge
    #3;
    chk("reset_q", Q, 4'd0);
    chk("reset_cao", {3'd0, CAO}, 4'd0);
    @(negedge CLK);
    CDN = 1'b1;

    apply(1'b0, 1'b1, 1'b0, 1'b0, 4'd10, "load10");
    // mid-cycle clear pulse
    #2; CDN = 1'b0; #1;
    chk("midclr_q", Q, 4'd0);
    m_q = 4'd0;
    #1; CDN = 1'b1;

    for (int i = 0; i < 16; i++) apply(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, $sformatf("cnt%0d", i));

    apply(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "preset");
    apply(1'b1, 1'b1, 1'b1, 1'b1, 4'd5, "ps_ld");
    apply(1'b0, 1'b1, 1'b1, 1'b1, 4'd5, "ld_over_cnt");
    apply(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, "hold_en0");
    apply(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, "hold_cai0");
    apply(1'b0, 1'b1, 1'b1, 1'b1, 4'd13, "load13");
    apply(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, "cnt_after13");
    apply(1'b0, 1'b1, 1'b0, 1'b0, 4'd15, "load15");
    apply(1'b0, 1'b1, 1'b1, 1'b1, 4'd2, "ld_at_tv");
    apply(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, "cnt_from2");

    // clear during load, held across edges
    #3;
    PS = 1'b0; LD = 1'b1; D = 4'd7; EN = 1'b1; CAI = 1'b1;
    CDN = 1'b0; #1;
    chk("clrld_now", Q, 4'd0);
    @(posedge CLK); #1;
    chk("clrld_e1", Q, 4'd0);
    @(posedge CLK); #1;
    chk("clrld_e2", Q, 4'd0);
    @(negedge CLK);
    CDN = 1'b1;
    m_q = 4'd0;
    @(posedge CLK); #1;
    chk("clrld_rel", Q, 4'd7);
    m_q = 4'd7;

    // two-stage cascade rollover
    @(negedge CLK);
    c0_ld = 1'b1; c0_d = 4'd15; c1_ld = 1'b1; c1_d = 4'd3; c_en = 1'b0;
    @(posedge CLK); #1;
    chk("casc_ld0", c0_q, 4'd15);
    chk("casc_ld1", c1_q, 4'd3);
    @(negedge CLK);
    c0_ld = 1'b0; c1_ld = 1'b0; c_en = 1'b1;
    #1;
    chk("casc_cao0", {3'd0, c0_cao}, 4'd1);
    chk("casc_cao1", {3'd0, c1_cao}, 4'd0);
    @(posedge CLK); #1;
    chk("casc_s0", c0_q, 4'd0);
    chk("casc_s1", c1_q, 4'd4);
    @(posedge CLK); #1;
    chk("casc_s0b", c0_q, 4'd1);
    chk("casc_s1b", c1_q, 4'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
